// File: rtl/reg_file_sequencer_if.sv
// rtl/reg_file_sequencer_if.sv - instruction handshake and register-file bus of the sequencer
interface reg_file_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [1:0] instr_rt;
  logic [7:0] instr_imm;
  logic [1:0] raddr0;
  logic [1:0] raddr1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       wren;
  logic       done;
  logic       flag_c;
  logic       flag_z;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm, rdata0, rdata1,
    output instr_ready, raddr0, raddr1, waddr, wdata, wren, done, flag_c, flag_z
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm, rdata0, rdata1,
    input  instr_ready, raddr0, raddr1, waddr, wdata, wren, done, flag_c, flag_z
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// rtl/reg_file_sequencer.sv - four-phase read/execute/write-back sequencer for a 4x8 2R1W register file
module reg_file_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE} state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] rd_q, rd_d;
  logic [7:0] imm_q, imm_d;
  logic [1:0] raddr0_q, raddr0_d;
  logic [1:0] raddr1_q, raddr1_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [1:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wren_q, wren_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic [8:0] alu;

  // Bit 8 carries ADD carry-out or SUB borrow; LI and AND never set it.
  always_comb begin
    alu = 9'd0;
    case (op_q)
      2'b00:   alu = {1'b0, opa_q} + {1'b0, opb_q};
      2'b01:   alu = {opa_q < opb_q, opa_q - opb_q};
      2'b10:   alu = {1'b0, imm_q};
      default: alu = {1'b0, opa_q & opb_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    raddr0_d = raddr0_q;
    raddr1_d = raddr1_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wren_d   = 1'b0;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          state_d  = ST_READ;
          op_d     = bus.instr_op;
          rd_d     = bus.instr_rd;
          imm_d    = bus.instr_imm;
          raddr0_d = bus.instr_rs;
          raddr1_d = bus.instr_rt;
        end
      end
      ST_READ: begin
        opa_d   = bus.rdata0;
        opb_d   = bus.rdata1;
        state_d = ST_EXEC;
      end
      // Result, flags and write strobe all land together at WRITE entry.
      ST_EXEC: begin
        waddr_d  = rd_q;
        wdata_d  = alu[7:0];
        flag_c_d = alu[8];
        flag_z_d = (alu[7:0] == 8'd0);
        wren_d   = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'd0;
      rd_q     <= 2'd0;
      imm_q    <= 8'd0;
      raddr0_q <= 2'd0;
      raddr1_q <= 2'd0;
      opa_q    <= 8'd0;
      opb_q    <= 8'd0;
      waddr_q  <= 2'd0;
      wdata_q  <= 8'd0;
      wren_q   <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      raddr0_q <= raddr0_d;
      raddr1_q <= raddr1_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wren_q   <= wren_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.raddr0      = raddr0_q;
  assign bus.raddr1      = raddr1_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.wren        = wren_q;
  assign bus.done        = wren_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_z      = flag_z_q;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// tb/tb_reg_file_sequencer.sv - randomized and directed bench with an in-order instruction model
module tb_reg_file_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_sequencer_if bus();
  reg_file_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Register file emulation driven purely by the DUT's write port.
  logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  assign bus.rdata0 = rf[bus.raddr0];
  assign bus.rdata1 = rf[bus.raddr1];
  initial forever begin
    @(posedge clk);
    if (bus.wren) rf[bus.waddr] = bus.wdata;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: architectural registers, one instruction in flight, busy = cycles left until idle.
  logic [7:0] mregs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         busy = 0;
  logic [1:0] pend_rd = 2'd0;
  logic [7:0] pend_r = 8'd0;
  logic       pend_c = 1'b0, pend_z = 1'b0;
  logic [1:0] exp_ra0 = 2'd0, exp_ra1 = 2'd0, exp_waddr = 2'd0;
  logic [7:0] exp_wdata = 8'd0;
  logic       exp_c = 1'b0, exp_z = 1'b0;

  function automatic logic [9:0] model_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] imm);
    int s;
    logic [7:0] r;
    logic c;
    case (op)
      2'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); c = (s > 255); end
      2'd1: begin s = int'(a) - int'(b); r = 8'((s + 256) % 256); c = (s < 0); end
      2'd2: begin r = imm; c = 1'b0; end
      default: begin r = a & b; c = 1'b0; end
    endcase
    return {c, (r == 8'd0), r};
  endfunction

  initial forever begin
    logic [9:0] res;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy = 0; exp_ra0 = 0; exp_ra1 = 0; exp_waddr = 0; exp_wdata = 0; exp_c = 0; exp_z = 0;
    end else if (busy == 0) begin
      if (bus.instr_valid) begin
        res = model_op(bus.instr_op, mregs[bus.instr_rs], mregs[bus.instr_rt], bus.instr_imm);
        pend_rd = bus.instr_rd; pend_r = res[7:0]; pend_z = res[8]; pend_c = res[9];
        exp_ra0 = bus.instr_rs; exp_ra1 = bus.instr_rt;
        busy = 3;
      end
    end else begin
      busy--;
      if (busy == 1) begin
        exp_waddr = pend_rd; exp_wdata = pend_r; exp_c = pend_c; exp_z = pend_z;
        mregs[pend_rd] = pend_r;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("instr_ready", bus.instr_ready, busy == 0);
    chk("wren", bus.wren, busy == 1);
    chk("done", bus.done, busy == 1);
    chk("raddr0", bus.raddr0, exp_ra0);
    chk("raddr1", bus.raddr1, exp_ra1);
    chk("waddr", bus.waddr, exp_waddr);
    chk("wdata", bus.wdata, exp_wdata);
    chk("flag_c", bus.flag_c, exp_c);
    chk("flag_z", bus.flag_z, exp_z);
  end

  task automatic wait_ready();
    for (int k = 0; k < 20 && !bus.instr_ready; k++) @(negedge clk);
    if (!bus.instr_ready) chk("ready_timeout", bus.instr_ready, 1);
  endtask

  // Called at a falling edge; returns at the falling edge inside the WRITE cycle.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm, input bit toggle_rd);
    wait_ready();
    bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs = rs; bus.instr_rt = rt; bus.instr_imm = imm;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 8 && !bus.done; k++) begin
      if (toggle_rd) bus.instr_rd = ~bus.instr_rd;
      @(negedge clk);
    end
    if (!bus.done) chk("done_timeout", bus.done, 1);
  endtask

  task automatic expect_write(input string nm, input logic [1:0] wa, input logic [7:0] wd,
                              input logic c, input logic z);
    chk({nm, "_waddr"}, bus.waddr, wa);
    chk({nm, "_wdata"}, bus.wdata, wd);
    chk({nm, "_flag_c"}, bus.flag_c, c);
    chk({nm, "_flag_z"}, bus.flag_z, z);
  endtask

  logic [7:0] vals [4];
  int         at [4];
  int         n;

  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = 2'd0; bus.instr_rd = 2'd0;
    bus.instr_rs = 2'd0; bus.instr_rt = 2'd0; bus.instr_imm = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_wren", bus.wren, 0);
      chk("idle_ready", bus.instr_ready, 1);
      chk("idle_wdata", bus.wdata, 0);
    end

    issue(2'd2, 2'd1, 2'd0, 2'd0, 8'hF0, 0); expect_write("li_f0", 2'd1, 8'hF0, 0, 0);
    issue(2'd2, 2'd2, 2'd0, 2'd0, 8'h20, 0); expect_write("li_20", 2'd2, 8'h20, 0, 0);
    issue(2'd0, 2'd3, 2'd1, 2'd2, 8'h00, 0); expect_write("add_carry", 2'd3, 8'h10, 1, 0);

    issue(2'd2, 2'd1, 2'd0, 2'd0, 8'h05, 0);
    issue(2'd2, 2'd2, 2'd0, 2'd0, 8'h07, 0);
    issue(2'd1, 2'd0, 2'd1, 2'd2, 8'h00, 0); expect_write("sub_borrow", 2'd0, 8'hFE, 1, 0);
    issue(2'd1, 2'd0, 2'd1, 2'd1, 8'h00, 0); expect_write("sub_zero", 2'd0, 8'h00, 0, 1);

    issue(2'd2, 2'd1, 2'd0, 2'd0, 8'h03, 0);
    wait_ready();
    bus.instr_op = 2'd0; bus.instr_rd = 2'd1; bus.instr_rs = 2'd1; bus.instr_rt = 2'd1;
    bus.instr_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (bus.done) begin vals[n] = bus.wdata; at[n] = k; n++; end
    end
    bus.instr_valid = 1'b0;
    chk("b2b_count", n, 4);
    if (n == 4) begin
      chk("b2b_latency", at[0], 2);
      chk("b2b_w0", vals[0], 8'h06);
      chk("b2b_w1", vals[1], 8'h0C);
      chk("b2b_w2", vals[2], 8'h18);
      chk("b2b_w3", vals[3], 8'h30);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", at[i] - at[i-1], 4);
    end

    issue(2'd2, 2'd2, 2'd0, 2'd0, 8'hF0, 0);
    issue(2'd2, 2'd3, 2'd0, 2'd0, 8'h3C, 0);
    issue(2'd3, 2'd2, 2'd2, 2'd3, 8'h00, 1); expect_write("and_self", 2'd2, 8'h30, 0, 0);

    wait_ready();
    bus.instr_op = 2'd0; bus.instr_rd = 2'd1; bus.instr_rs = 2'd1; bus.instr_rt = 2'd1;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wren", bus.wren, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_raddr0", bus.raddr0, 0);
    chk("rst_ready", bus.instr_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_wren", bus.wren, 0);
    end
    #2 rst_n = 1'b1;
    issue(2'd2, 2'd1, 2'd0, 2'd0, 8'hAA, 0); expect_write("li_after_rst", 2'd1, 8'hAA, 0, 0);

    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      bus.instr_op  = 2'($urandom_range(0, 3));
      bus.instr_rd  = 2'($urandom_range(0, 3));
      bus.instr_rs  = 2'($urandom_range(0, 3));
      bus.instr_rt  = 2'($urandom_range(0, 3));
      bus.instr_imm = 8'($urandom_range(0, 255));
      bus.instr_valid = ($urandom_range(0, 2) != 0);
    end
    bus.instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("final_regs", rf[i], mregs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
